// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB register: word loads/stores over a req/ack
// data port, upstream stall while an access is outstanding, timeout abort.
module mem_wb_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic [4:0]  rd,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        bus_error
);

  typedef enum logic {IDLE, ACCESS} state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        rw_lat_q, rw_lat_d;
  logic [4:0]  rd_lat_q, rd_lat_d;
  logic        wbv_q, wbv_d, wbrw_q, wbrw_d, berr_q, berr_d;
  logic [4:0]  wbrd_q, wbrd_d;
  logic [31:0] wbdata_q, wbdata_d;

  logic mem_op, misal;
  assign mem_op = mem_read | mem_write;
  assign misal  = |alu_result[1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rw_lat_d = rw_lat_q;
    rd_lat_d = rd_lat_q;
    wbv_d    = wbv_q;
    wbrw_d   = wbrw_q;
    wbrd_d   = wbrd_q;
    wbdata_d = wbdata_q;
    berr_d   = 1'b0;
    stall    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!valid_in) begin
          wbv_d  = 1'b0;
          wbrw_d = 1'b0;
        end else if (!mem_op) begin
          wbv_d    = 1'b1;
          wbrw_d   = reg_write;
          wbrd_d   = rd;
          wbdata_d = alu_result;
        end else if (misal) begin
          // Misaligned access retires immediately as an error, no bus cycle.
          wbv_d  = 1'b1;
          wbrw_d = 1'b0;
          berr_d = 1'b1;
        end else begin
          stall    = 1'b1;
          state_d  = ACCESS;
          req_d    = 1'b1;
          we_d     = mem_write & ~mem_read;
          addr_d   = alu_result;
          wdata_d  = store_data;
          rd_lat_d = rd;
          rw_lat_d = reg_write;
          cnt_d    = '0;
          wbv_d    = 1'b0;
          wbrw_d   = 1'b0;
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          wbv_d   = 1'b1;
          wbrd_d  = rd_lat_q;
          if (we_q) begin
            wbrw_d   = 1'b0;
            wbdata_d = addr_q;
          end else begin
            wbrw_d   = rw_lat_q;
            wbdata_d = dmem_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          req_d   = 1'b0;
          wbv_d   = 1'b1;
          wbrw_d  = 1'b0;
          berr_d  = 1'b1;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rw_lat_q <= 1'b0;
      rd_lat_q <= '0;
      wbv_q    <= 1'b0;
      wbrw_q   <= 1'b0;
      wbrd_q   <= '0;
      wbdata_q <= '0;
      berr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rw_lat_q <= rw_lat_d;
      rd_lat_q <= rd_lat_d;
      wbv_q    <= wbv_d;
      wbrw_q   <= wbrw_d;
      wbrd_q   <= wbrd_d;
      wbdata_q <= wbdata_d;
      berr_q   <= berr_d;
    end
  end

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign wb_valid     = wbv_q;
  assign wb_reg_write = wbrw_q;
  assign wb_rd        = wbrd_q;
  assign wb_data      = wbdata_q;
  assign bus_error    = berr_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed cases then random instruction stream,
// expectations derived per instruction from the stage's retirement rules.
module tb_mem_wb_stage;
  localparam int TO = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] alu_result = '0, store_data = '0, dmem_rdata = '0;
  logic        mem_read = 1'b0, mem_write = 1'b0, reg_write = 1'b0, dmem_ack = 1'b0;
  logic [4:0]  rd = '0;
  logic        stall, dmem_req, dmem_we, wb_valid, wb_reg_write, bus_error;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [4:0]  wb_rd;

  int total = 0;
  int bad = 0;

  mem_wb_stage #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .alu_result(alu_result),
    .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .rd(rd), .stall(stall), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .wb_valid(wb_valid),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .bus_error(bus_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".req"}, dmem_req, 0);
    chk({tag, ".we"}, dmem_we, 0);
    chk({tag, ".addr"}, dmem_addr, 0);
    chk({tag, ".wdata"}, dmem_wdata, 0);
    chk({tag, ".wbv"}, wb_valid, 0);
    chk({tag, ".wbrw"}, wb_reg_write, 0);
    chk({tag, ".wbrd"}, wb_rd, 0);
    chk({tag, ".wbdata"}, wb_data, 0);
    chk({tag, ".berr"}, bus_error, 0);
  endtask

  task automatic idle(input int n, input logic late_ack);
    for (int i = 0; i < n; i++) begin
      valid_in = 1'b0;
      dmem_ack = late_ack;
      dmem_rdata = $urandom;
      #1 chk("idle.stall", stall, 0);
      cyc();
      dmem_ack = 1'b0;
      chk("idle.wbv", wb_valid, 0);
      chk("idle.berr", bus_error, 0);
      chk("idle.req", dmem_req, 0);
    end
  endtask

  // kind: 0 ALU, 1 load, 2 store, 3 both flags (load). ack_dly: ACCESS cycle
  // carrying the ack (1 = first), 0 = never ack -> timeout.
  // Called at a negedge, returns at the negedge after retirement.
  task automatic run_instr(input int kind, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [4:0] r,
                           input logic rw, input int ack_dly);
    logic ld, st, mem, st_only;
    logic [31:0] rdat;
    ld = (kind == 1) || (kind == 3);
    st = (kind == 2) || (kind == 3);
    mem = ld || st;
    st_only = st && !ld;
    rdat = $urandom;
    valid_in = 1'b1; alu_result = addr; store_data = sdata;
    mem_read = ld; mem_write = st; rd = r; reg_write = rw; dmem_ack = 1'b0;
    #1;
    if (!mem || addr[1:0] != 2'b00) begin
      chk("acc.stall", stall, 0);
      cyc();
      valid_in = 1'b0;
      chk("ret.wbv", wb_valid, 1);
      chk("ret.req", dmem_req, 0);
      if (!mem) begin
        chk("alu.wbrw", wb_reg_write, rw);
        chk("alu.wbrd", wb_rd, r);
        chk("alu.wbdata", wb_data, addr);
        chk("alu.berr", bus_error, 0);
      end else begin
        chk("mis.wbrw", wb_reg_write, 0);
        chk("mis.berr", bus_error, 1);
      end
      return;
    end
    chk("acc.stall", stall, 1);
    cyc();
    for (int k = 1; k <= TO; k++) begin
      chk("acs.req", dmem_req, 1);
      chk("acs.we", dmem_we, st_only);
      chk("acs.addr", dmem_addr, addr);
      if (st_only) chk("acs.wdata", dmem_wdata, sdata);
      chk("acs.wbv", wb_valid, 0);
      chk("acs.berr", bus_error, 0);
      if (k == ack_dly) begin
        dmem_ack = 1'b1; dmem_rdata = rdat;
        #1 chk("ack.stall", stall, 0);
        cyc();
        dmem_ack = 1'b0; valid_in = 1'b0;
        chk("ack.wbv", wb_valid, 1);
        chk("ack.req", dmem_req, 0);
        chk("ack.berr", bus_error, 0);
        chk("ack.wbrd", wb_rd, r);
        chk("ack.wbrw", wb_reg_write, st_only ? 1'b0 : rw);
        chk("ack.wbdata", wb_data, st_only ? addr : rdat);
        return;
      end
      #1 chk("wait.stall", stall, (k == TO) ? 1'b0 : 1'b1);
      cyc();
    end
    valid_in = 1'b0;
    chk("to.wbv", wb_valid, 1);
    chk("to.wbrw", wb_reg_write, 0);
    chk("to.berr", bus_error, 1);
    chk("to.req", dmem_req, 0);
    idle(1, 1'b1);
  endtask

  initial begin
    int kind, dly;
    logic [31:0] a;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_all_zero("rst");
    chk("rst.stall", stall, 0);
    reset = 1'b0;

    run_instr(0, 32'h0000_1234, 32'h0, 5'd7, 1'b1, 1);
    run_instr(1, 32'h0000_0100, 32'h0, 5'd3, 1'b1, 3);
    run_instr(2, 32'h0000_0204, 32'hCAFE_0001, 5'd4, 1'b1, 1);
    run_instr(1, 32'h0000_0102, 32'h0, 5'd5, 1'b1, 1);
    idle(1, 1'b0);
    run_instr(1, 32'h0000_0300, 32'h0, 5'd6, 1'b1, 0);
    run_instr(3, 32'h0000_0040, 32'h1111_2222, 5'd9, 1'b1, 2);

    // Reset during the second ACCESS cycle, then a late ack must be ignored.
    valid_in = 1'b1; alu_result = 32'h0000_0400; mem_read = 1'b1; mem_write = 1'b0;
    rd = 5'd10; reg_write = 1'b1;
    cyc();
    cyc();
    chk("mid.req", dmem_req, 1);
    reset = 1'b1;
    cyc();
    valid_in = 1'b0;
    chk_all_zero("mid");
    reset = 1'b0;
    idle(1, 1'b1);
    run_instr(0, 32'h0000_5678, 32'h0, 5'd11, 1'b1, 1);

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 3);
      a = $urandom;
      if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
      dly = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
      run_instr(kind, a, $urandom, 5'($urandom), 1'($urandom), dly);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
